keypad_scanner: RTL and testbench

Synthesizable scanner for a passive row/column matrix keypad. It drives one column low at a time, samples the active-low rows, debounces the result, and emits a one-cycle key event with a key code. Optional auto-repeat generates further events while a key is held. It sits between the keypad pins and the clock's time/alarm-setting control logic, replacing open-loop key decoding.

---
 rtl/keypad_scanner.sv | 253 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: row/column matrix keypad scanner with debounce and auto-repeat.
//
// The scanner drives one active-low column at a time and samples the
// active-low rows through a two-flop synchronizer. It collects one result per
// frame (NONE, SINGLE or MULTI), debounces presses and releases over whole
// frames, and emits a one-cycle key event. While a key is held it can also
// emit auto-repeat events.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   rows       keypad rows, pulled up, 0 = switch closed on the driven column (async)
//   columns    column drive, active-low, one bit low at a time once scanning
//   key_code   code of the current / last accepted key
//   key_valid  one-cycle pulse per press or repeat event
//   key_down   level, a debounced key is held
//   multi_key  level, the last completed frame saw more than one closed switch
module keypad_scanner #(
  parameter int NUM_ROWS     = 4,
  parameter int NUM_COLS     = 3,
  parameter int SCAN_DIV     = 8,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16,
  parameter int MAP_PHONE    = 1,
  localparam int CODE_W = ($clog2(NUM_ROWS*NUM_COLS) < 1) ? 1 : $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] columns,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_down,
  output logic                multi_key
);

  localparam int COL_W   = ($clog2(NUM_COLS) < 1) ? 1 : $clog2(NUM_COLS);
  localparam int DIV_W   = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam int DB_W    = ($clog2(DEBOUNCE + 1) < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = ($clog2(REP_MAX + 1) < 1) ? 1 : $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  // Column scan
  logic             running;
  logic [COL_W-1:0] col_idx;
  logic [COL_W-1:0] col_next;
  logic [DIV_W-1:0] div_cnt;
  logic             slot_end;
  logic             frame_end;

  // Row synchronizer
  logic [NUM_ROWS-1:0] rows_meta;
  logic [NUM_ROWS-1:0] rows_sync;

  // Per-column and per-frame results
  logic [1:0]        col_cnt;
  logic [CODE_W-1:0] col_raw;
  logic [1:0]        acc_cnt;
  logic [CODE_W-1:0] acc_raw;
  logic [2:0]        sum_cnt;
  logic [1:0]        frame_cnt;
  logic [CODE_W-1:0] frame_raw;
  logic              frame_single;
  logic              frame_multi;

  // Key FSM
  state_t            state;
  logic [DB_W-1:0]   cnt;
  logic [CODE_W-1:0] cand;
  logic [REP_W-1:0]  rep_cnt;
  logic              rep_first;
  logic              match;
  logic              db_hit;
  logic              rep_hit;

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
    logic [NUM_COLS-1:0] v;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      v[c] = (c != 32'(idx));
    end
    return v;
  endfunction

  function automatic logic [CODE_W-1:0] map_code(input logic [CODE_W-1:0] raw);
    if (MAP_PHONE == 1 && NUM_ROWS == 4 && NUM_COLS == 3) begin
      if (32'(raw) < 32'd9)        return CODE_W'(32'(raw) + 32'd1);
      else if (32'(raw) == 32'd9)  return CODE_W'(10);
      else if (32'(raw) == 32'd10) return '0;
      else                         return raw;
    end
    return raw;
  endfunction

  always_comb begin
    slot_end  = running && (div_cnt == DIV_W'(SCAN_DIV - 1));
    frame_end = slot_end && (col_idx == COL_W'(NUM_COLS - 1));
    col_next  = (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
  end

  // The first cycle out of reset only starts the scan, so column 0 is then
  // low for a full SCAN_DIV cycles with div_cnt aligned to the drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      col_idx <= '0;
      div_cnt <= '0;
      columns <= '1;
    end else if (!running) begin
      running <= 1'b1;
      columns <= col_drive('0);
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      col_idx <= col_next;
      columns <= col_drive(col_next);
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta <= '1;
      rows_sync <= '1;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  // Count closed switches in the driven column (saturating at 2) and the raw
  // index of the last one found; only meaningful when exactly one is closed.
  always_comb begin
    col_cnt = '0;
    col_raw = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!rows_sync[r]) begin
        if (col_cnt != 2'd2) col_cnt = col_cnt + 1'b1;
        col_raw = CODE_W'((NUM_ROWS - 1 - r) * NUM_COLS + (NUM_COLS - 1 - 32'(col_idx)));
      end
    end
  end

  always_comb begin
    sum_cnt      = {1'b0, acc_cnt} + {1'b0, col_cnt};
    frame_cnt    = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    frame_raw    = (col_cnt != 2'd0) ? col_raw : acc_raw;
    frame_single = (frame_cnt == 2'd1);
    frame_multi  = (frame_cnt == 2'd2);
    match        = frame_single && (frame_raw == cand);
    db_hit       = (32'(cnt) + 32'd1 >= 32'(DEBOUNCE));
    rep_hit      = (32'(rep_cnt) + 32'd1 ==
                    (rep_first ? 32'(REPEAT_DELAY) : 32'(REPEAT_RATE)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt <= '0;
      acc_raw <= '0;
    end else if (slot_end) begin
      acc_cnt <= frame_end ? 2'd0 : frame_cnt;
      if (col_cnt != 2'd0) acc_raw <= col_raw;
    end
  end

  // cand keeps the raw index of the debounced key through HELD and REL_DB;
  // rep_cnt is left untouched in REL_DB so a bounce back to HELD resumes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        multi_key <= frame_multi;
        unique case (state)
          IDLE: begin
            if (frame_single) begin
              cand <= frame_raw;
              if (DEBOUNCE <= 1) begin
                key_code  <= map_code(frame_raw);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b1;
                state     <= HELD;
              end else begin
                cnt   <= DB_W'(1);
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (match) begin
              if (db_hit) begin
                key_code  <= map_code(cand);
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b1;
                state     <= HELD;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (match) begin
              if (REPEAT_RATE != 0) begin
                if (rep_hit) begin
                  key_valid <= 1'b1;
                  rep_cnt   <= '0;
                  rep_first <= 1'b0;
                end else begin
                  rep_cnt <= rep_cnt + 1'b1;
                end
              end
            end else if (DEBOUNCE <= 1) begin
              key_down <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt   <= DB_W'(1);
              state <= REL_DB;
            end
          end
          REL_DB: begin
            if (match) begin
              state <= HELD;
            end else if (db_hit) begin
              key_down <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner in a 4x3 phone
// layout with SCAN_DIV=4, DEBOUNCE=2, REPEAT_DELAY=4, REPEAT_RATE=2.
// A keypad model pulls rows[r] low when switch (r,c) is closed and column c
// is driven low. Expected key events are queued per phase and popped when
// key_valid pulses.
module tb_keypad_scanner;

  localparam int NR = 4;
  localparam int NC = 3;
  localparam int CW = 4;
  localparam int FRAME = 12;

  typedef struct {
    logic [11:0] keys;
    int          frames;
    int          n_ev;
    logic [3:0]  code;
    logic        down;
    logic        multi;
    string       name;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] rows;
  logic [NC-1:0] columns;
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_down;
  logic          multi_key;
  logic [11:0]   keys;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];
  vec_t tbl[17];

  always #5 clk = ~clk;

  keypad_scanner #(
    .NUM_ROWS(4), .NUM_COLS(3), .SCAN_DIV(4), .DEBOUNCE(2),
    .REPEAT_DELAY(4), .REPEAT_RATE(2), .MAP_PHONE(1)
  ) dut (
    .clk(clk), .reset(reset), .rows(rows), .columns(columns),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down),
    .multi_key(multi_key)
  );

  // keys bit index = r*NC + c
  always_comb begin
    rows = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (keys[r*NC + c] && !columns[c]) rows[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_event: key_valid with code %0d, none expected (t=%0t)",
                 key_code, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("event_code", 32'(key_code), 32'(e));
      end
    end
  end

  task automatic wait_frame_start();
    logic [2:0] prev;
    bit found;
    prev = columns;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (columns == 3'b110 && prev == 3'b011) found = 1;
      prev = columns;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_sync: columns %b, expected 110 after 011 within 40 cycles", columns);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_col;
    logic [2:0] one;
    int lat;
    bit got;

    tbl[0]  = '{12'h800, 2,  1, 4'd1,  1'b1, 1'b0, "t2_press"};
    tbl[1]  = '{12'h000, 1,  0, 4'd1,  1'b1, 1'b0, "t2_rel1"};
    tbl[2]  = '{12'h000, 1,  0, 4'd1,  1'b0, 1'b0, "t2_rel2"};
    tbl[3]  = '{12'h002, 1,  0, 4'd1,  1'b0, 1'b0, "t3_bounce"};
    tbl[4]  = '{12'h000, 1,  0, 4'd1,  1'b0, 1'b0, "t3_gap"};
    tbl[5]  = '{12'h002, 2,  1, 4'd0,  1'b1, 1'b0, "t3_stable"};
    tbl[6]  = '{12'h000, 2,  0, 4'd0,  1'b0, 1'b0, "t3_rel"};
    tbl[7]  = '{12'h004, 12, 5, 4'd10, 1'b1, 1'b0, "t4_hold"};
    tbl[8]  = '{12'h000, 2,  0, 4'd10, 1'b0, 1'b0, "t4_rel"};
    tbl[9]  = '{12'h090, 2,  0, 4'd10, 1'b0, 1'b1, "t5_multi"};
    tbl[10] = '{12'h080, 2,  1, 4'd5,  1'b1, 1'b0, "t5_single"};
    tbl[11] = '{12'h000, 2,  0, 4'd5,  1'b0, 1'b0, "t5_rel"};
    tbl[12] = '{12'h800, 2,  1, 4'd1,  1'b1, 1'b0, "rb_press"};
    tbl[13] = '{12'h000, 1,  0, 4'd1,  1'b1, 1'b0, "rb_gap"};
    tbl[14] = '{12'h800, 1,  0, 4'd1,  1'b1, 1'b0, "rb_back"};
    tbl[15] = '{12'h000, 2,  0, 4'd1,  1'b0, 1'b0, "rb_rel"};
    tbl[16] = '{12'h001, 2,  1, 4'd11, 1'b1, 1'b0, "t6_press"};

    // Reset values and the column scan sequence
    reset = 1'b1;
    keys  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_columns",   32'(columns),   32'h7);
    check("rst_key_code",  32'(key_code),  32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_down",  32'(key_down),  32'h0);
    check("rst_multi_key", 32'(multi_key), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(posedge clk); #1;
      one = 3'b001;
      exp_col = ~(one << ((i / 4) % 3));
      check("scan_columns", 32'(columns), 32'(exp_col));
      check("idle_outputs", 32'({key_valid, key_down, multi_key, key_code}), 32'h0);
    end

    // Frame-aligned phases from the table
    wait_frame_start();
    for (int i = 0; i < 17; i++) begin
      keys = tbl[i].keys;
      for (int e = 0; e < tbl[i].n_ev; e++) exp_q.push_back(tbl[i].code);
      repeat (tbl[i].frames * FRAME) @(posedge clk);
      @(negedge clk); #1;
      check({tbl[i].name, "_missing_events"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check({tbl[i].name, "_key_down"},  32'(key_down),  32'(tbl[i].down));
      check({tbl[i].name, "_multi_key"}, 32'(multi_key), 32'(tbl[i].multi));
      check({tbl[i].name, "_key_code"},  32'(key_code),  32'(tbl[i].code));
    end

    // Mid-frame reset while (r0,c0) is held, then re-acceptance
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_columns",   32'(columns),   32'h7);
    check("t6_rst_key_code",  32'(key_code),  32'h0);
    check("t6_rst_key_valid", 32'(key_valid), 32'h0);
    check("t6_rst_key_down",  32'(key_down),  32'h0);
    check("t6_rst_multi_key", 32'(multi_key), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(4'd11);
    lat = 0;
    got = 0;
    for (int k = 0; k < 39 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (key_valid) got = 1;
    end
    check("t6_latency_cycles", 32'(lat), 32'd25);
    @(negedge clk); #1;
    check("t6_missing_events", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("t6_key_down", 32'(key_down), 32'd1);
    check("t6_key_code", 32'(key_code), 32'd11);

    keys = '0;
    repeat (3 * FRAME) @(posedge clk);
    @(negedge clk); #1;
    check("t6_rel_key_down", 32'(key_down), 32'd0);
    check("t6_rel_key_code", 32'(key_code), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
